cacheline_arbiter: RTL and testbench

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/cacheline_arbiter_pkg.sv | 18 +
 rtl/cacheline_arbiter_if.sv | 37 +++
 rtl/cacheline_arbiter_reg.sv | 18 +
 rtl/cacheline_arbiter.sv | 102 ++++++++++
 tb/tb_cacheline_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, grant identifiers and
// the line-offset width that is cleared on every memory address.
package cacheline_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_SERVE = 2'd1,
    D_SERVE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_grant_t;

  localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and line memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface cacheline_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter_reg.sv
// Load-enabled register with asynchronous active-high clear, used to hold
// the captured address and write data of the transaction in flight.
module cacheline_arbiter_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Serialises icache refills and dcache refills/writebacks onto one line memory port.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise dcache wins.
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_arbiter_if.slave   bus
);

  arb_state_t        state_q, state_d;
  arb_grant_t        grant;
  logic              i_req, d_req;
  logic              grant_valid, grant_write;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_sel, addr_q;
  logic [LINE_W-1:0] wdata_q;

`ifdef ARB_RR_EN
  arb_grant_t        last_q;
`endif

  // Grant selection; read+write together from dcache is a writeback first
  always_comb begin
    i_req = bus.i_read;
    d_req = bus.d_read | bus.d_write;
    grant = DCACHE;
`ifdef ARB_RR_EN
    if (i_req && (!d_req || last_q == DCACHE)) grant = ICACHE;
`else
    if (i_req && !d_req) grant = ICACHE;
`endif
    grant_valid = (state_q == IDLE) && (i_req || d_req);
    grant_write = (grant == DCACHE) && bus.d_write;
    addr_sel    = (grant == ICACHE) ? bus.i_address : bus.d_address;
    addr_sel[LINE_OFFSET_W-1:0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_valid) op_write_q <= grant_write;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_q <= ICACHE;
    else if (grant_valid) last_q <= grant;
  end
`endif

  cacheline_arbiter_reg #(.W(ADDR_W)) u_addr_reg (
    .clk  (clk),
    .rst  (rst),
    .load (grant_valid),
    .d    (addr_sel),
    .q    (addr_q)
  );

  cacheline_arbiter_reg #(.W(LINE_W)) u_wdata_reg (
    .clk  (clk),
    .rst  (rst),
    .load (grant_valid),
    .d    (bus.d_wdata),
    .q    (wdata_q)
  );

  // Strobes come only from the registered op, so they start the cycle after grant
  always_comb begin
    state_d       = state_q;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = (grant == ICACHE) ? I_SERVE : D_SERVE;
      end
      I_SERVE, D_SERVE: begin
        bus.mem_read  = !op_write_q;
        bus.mem_write = op_write_q;
        bus.i_resp    = (state_q == I_SERVE) && bus.mem_resp;
        bus.d_resp    = (state_q == D_SERVE) && bus.mem_resp;
        if (bus.mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Randomised self-checking bench for cacheline_arbiter with a transaction-level
// reference model of grant choice, address alignment and response routing.
module tb_cacheline_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   last_d;

  cacheline_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

  cacheline_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Returns 1 when dcache should win the grant under the arbitration rules
  function automatic bit model_pick_d(bit ir, bit dq);
    if (!ir) return 1'b1;
    if (!dq) return 1'b0;
`ifdef ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_txn(input string name, input bit ir, input bit dr, input bit dw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [255:0] wd, input int lat);
    bit           pd;
    bit           wr;
    logic [31:0]  ea;
    logic [255:0] rd;
    pd = model_pick_d(ir, dr | dw);
    wr = pd && dw;
    ea = (pd ? da : ia) & 32'hFFFF_FFE0;
    bus.i_read = ir; bus.d_read = dr; bus.d_write = dw;
    bus.i_address = ia; bus.d_address = da; bus.d_wdata = wd;
    tick();
    last_d = pd;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_address = 32'h80; bus.i_address = $urandom; bus.d_wdata = rand_line();
    rd = '0;
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        rd = rand_line();
        bus.mem_resp = 1'b1;
        bus.mem_rdata = rd;
      end
      #1;
      checks++;
      if (bus.mem_read !== !wr || bus.mem_write !== wr) begin
        errors++;
        $display("FAIL %s strobe c=%0d: got rd=%b wr=%b required rd=%b wr=%b",
                 name, c, bus.mem_read, bus.mem_write, !wr, wr);
      end
      checks++;
      if (bus.mem_address !== ea) begin
        errors++;
        $display("FAIL %s addr c=%0d: got %h required %h", name, c, bus.mem_address, ea);
      end
      if (wr) begin
        checks++;
        if (bus.mem_wdata !== wd) begin
          errors++;
          $display("FAIL %s wdata c=%0d: got %h required %h", name, c, bus.mem_wdata, wd);
        end
      end
      checks++;
      if (bus.i_resp !== (c == lat && !pd) || bus.d_resp !== (c == lat && pd)) begin
        errors++;
        $display("FAIL %s resp c=%0d: got i=%b d=%b required i=%b d=%b", name, c,
                 bus.i_resp, bus.d_resp, (c == lat && !pd), (c == lat && pd));
      end
      if (c == lat) begin
        checks++;
        if (bus.i_rdata !== rd || bus.d_rdata !== rd) begin
          errors++;
          $display("FAIL %s rdata: got i=%h d=%h required %h", name, bus.i_rdata, bus.d_rdata, rd);
        end
      end
      tick();
    end
    bus.mem_resp = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      errors++;
      $display("FAIL %s idle_after: got %b required 0000", name,
               {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.i_address = '0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    last_d = 1'b0;
    #3;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0
        || bus.mem_address !== 32'h0 || bus.mem_wdata !== 256'h0) begin
      errors++;
      $display("FAIL reset_state: got ctl=%b addr=%h required ctl=0000 addr=0 wdata=0",
               {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, bus.mem_address);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    do_txn("icache_read_0x60", 1'b1, 1'b0, 1'b0, 32'h60, 32'h0, '0, 3);
    do_txn("dcache_wb_0x1234", 1'b0, 1'b0, 1'b1, 32'h0, 32'h1234, {32{8'hA5}}, 2);
    do_txn("dcache_rd_wr_both", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_5A5F, rand_line(), 1);
  endtask

  task automatic test_spurious_resp();
    for (int c = 0; c < 3; c++) begin
      bus.mem_resp = 1'b1;
      bus.mem_rdata = rand_line();
      #1;
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
        errors++;
        $display("FAIL spurious_resp c=%0d: got %b required 0000", c,
                 {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp});
      end
      tick();
    end
    bus.mem_resp = 1'b0;
    do_txn("after_spurious", 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, '0, 0);
  endtask

  task automatic test_reset_mid();
    bus.d_write = 1'b1;
    bus.d_address = 32'h0000_0440;
    bus.d_wdata = rand_line();
    tick();
    bus.d_write = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got mem_write=%b required 1", bus.mem_write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got rd=%b wr=%b addr=%h required 0 0 0",
               bus.mem_read, bus.mem_write, bus.mem_address);
    end
    bus.mem_resp = 1'b1;
    #1;
    checks++;
    if (bus.d_resp !== 1'b0 || bus.i_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resp: got i=%b d=%b required 0 0", bus.i_resp, bus.d_resp);
    end
    tick();
    rst = 1'b0;
    last_d = 1'b0;
    tick();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_late_resp: got %b required 0000",
               {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp});
    end
    bus.mem_resp = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bit          p;
    logic [31:0] ia, da, ea;
    ia = 32'h0000_2040;
    da = 32'h0000_3080;
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    bus.i_address = ia; bus.d_address = da;
    for (int r = 0; r < 2; r++) begin
      p = model_pick_d(1'b1, 1'b1);
      ea = p ? da : ia;
      tick();
      last_d = p;
      if (r == 1) begin
        bus.i_read = 1'b0; bus.d_read = 1'b0;
      end
      #1;
      checks++;
      if (bus.mem_address !== ea || bus.mem_read !== 1'b1) begin
        errors++;
        $display("FAIL b2b_grant r=%0d: got addr=%h rd=%b required addr=%h rd=1",
                 r, bus.mem_address, bus.mem_read, ea);
      end
      bus.mem_resp = 1'b1;
      #1;
      checks++;
      if (bus.d_resp !== p || bus.i_resp !== !p) begin
        errors++;
        $display("FAIL b2b_resp r=%0d: got i=%b d=%b required i=%b d=%b",
                 r, bus.i_resp, bus.d_resp, !p, p);
      end
      tick();
      bus.mem_resp = 1'b0;
      #1;
      checks++;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle_gap r=%0d: got rd=%b wr=%b required 0 0",
                 r, bus.mem_read, bus.mem_write);
      end
    end
  endtask

  task automatic test_random();
    bit ir, dr, dw;
    for (int n = 0; n < 24; n++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!ir && !dr && !dw) ir = 1'b1;
      do_txn("random", ir, dr, dw, $urandom, $urandom, rand_line(), $urandom_range(0, 3));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_spurious_resp();
    test_reset_mid();
    test_back_to_back();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
